serial_adder: RTL and testbench

Parametrised, multi-cycle ripple adder. It computes {cout,sum} = a + b + cin over WIDTH bits, processing DIGIT bits per clock through a registered carry. Operands enter on a valid/ready input handshake, and the result leaves on a valid/ready output handshake. It reuses the team's single-bit full_adder (port order sum, carry, a, b, cin) as the arithmetic cell. It also adds signed-overflow reporting and backpressure, which the combinational adder does not have.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_digit_adder.sv | 33 +++
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state constants and the
// elaboration-time parameter legality check.
package serial_adder_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Legal when the width is positive and splits into whole digits.
   function automatic bit params_ok(input int width, input int digit);
      return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the arithmetic cell shared across the codebase.
module full_adder (
   output logic sum,
   output logic carry,
   input  logic a,
   input  logic b,
   input  logic cin
);

   assign sum   = a ^ b ^ cin;
   assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-bit ripple adder built from a chain of full_adder cells. Besides the
// carry out it exposes the carry into the top bit for overflow detection.
module digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   assign c[0] = cin;

   generate
      for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
         full_adder u_fa (
            .sum   (s[gi]),
            .carry (c[gi+1]),
            .a     (a[gi]),
            .b     (b[gi]),
            .cin   (c[gi])
         );
      end
   endgenerate

   assign co    = c[DIGIT];
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle ripple adder: adds DIGIT bits per clock through a registered
// carry, with valid/ready handshakes on both operand and result sides.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = $clog2(NDIG) + 1;

   generate
      if (!params_ok(WIDTH, DIGIT)) begin : g_param_err
         $error("serial_adder: WIDTH (%0d) must be >= 1 and a multiple of DIGIT (%0d)", WIDTH, DIGIT);
      end
   endgenerate

   logic [1:0]       state_reg;
   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   logic [WIDTH-1:0] sum_sh_reg;
   logic             carry_reg;
   logic             cout_reg;
   logic             ovf_reg;
   logic [CW-1:0]    cnt_reg;

   logic [DIGIT-1:0] dig_s;
   logic             dig_co;
   logic             dig_cmsb;
   logic             accept;
   logic             last_dig;

   // A held result can be handed off and replaced in the same cycle, so
   // in_ready looks straight through to out_ready while in DONE.
   assign in_ready = (state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready);
   assign accept   = in_valid && in_ready;
   assign last_dig = (cnt_reg == CW'(NDIG - 1));

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a     (a_sh_reg[DIGIT-1:0]),
      .b     (b_sh_reg[DIGIT-1:0]),
      .cin   (carry_reg),
      .s     (dig_s),
      .co    (dig_co),
      .c_msb (dig_cmsb)
   );

   // FSM plus datapath: load on accept, one digit per BUSY cycle, hold in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         a_sh_reg   <= '0;
         b_sh_reg   <= '0;
         sum_sh_reg <= '0;
         carry_reg  <= 1'b0;
         cout_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
         cnt_reg    <= '0;
      end else if (accept) begin
         a_sh_reg  <= a;
         b_sh_reg  <= b;
         carry_reg <= cin;
         cnt_reg   <= '0;
         state_reg <= S_BUSY;
      end else begin
         case (state_reg)
            S_BUSY: begin
               a_sh_reg   <= a_sh_reg >> DIGIT;
               b_sh_reg   <= b_sh_reg >> DIGIT;
               // New digit enters at the MSB end; after NDIG shifts it lands in place.
               sum_sh_reg <= WIDTH'({dig_s, sum_sh_reg} >> DIGIT);
               carry_reg  <= dig_co;
               cnt_reg    <= cnt_reg + CW'(1);
               if (last_dig) begin
                  cout_reg  <= dig_co;
                  ovf_reg   <= dig_co ^ dig_cmsb;
                  state_reg <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_reg <= S_IDLE;
               end
            end
            S_IDLE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign out_valid = (state_reg == S_DONE);
   assign sum       = sum_sh_reg;
   assign cout      = cout_reg;
   assign overflow  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three configurations (8/1, 16/4, 8/8)
// checked every cycle against a transaction-level timing/arithmetic model.
module tb_serial_adder;

   localparam int NI = 3;
   localparam int W_T [NI] = '{8, 16, 8};
   localparam int N_T [NI] = '{8, 4, 1};

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic        in_valid_v  [NI];
   logic        out_ready_v [NI];
   logic        cin_v       [NI];
   logic [15:0] a_v         [NI];
   logic [15:0] b_v         [NI];
   logic        in_ready_v  [NI];
   logic        out_valid_v [NI];
   logic        cout_v      [NI];
   logic        ovf_v       [NI];
   logic [15:0] sum_v       [NI];
   logic [7:0]  sum0;
   logic [15:0] sum1;
   logic [7:0]  sum2;

   int checks = 0;
   int failures = 0;
   int n = 0;
   int acc_n = 0;
   bit rnd_done = 1'b0;

   // model state: at most one operation in flight per DUT
   bit          have_op  [NI];
   int          acc_edge [NI];
   logic [15:0] es       [NI];
   logic        ec       [NI];
   logic        eo       [NI];

   always #5 clk = ~clk;

   // edge counter used to time-stamp accepts and results
   always @(posedge clk) n <= n + 1;

   assign sum_v[0] = {8'h00, sum0};
   assign sum_v[1] = sum1;
   assign sum_v[2] = {8'h00, sum2};

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin_v[0]), .out_valid(out_valid_v[0]),
      .out_ready(out_ready_v[0]), .sum(sum0), .cout(cout_v[0]), .overflow(ovf_v[0]));

   serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .out_valid(out_valid_v[1]),
      .out_ready(out_ready_v[1]), .sum(sum1), .cout(cout_v[1]), .overflow(ovf_v[1]));

   serial_adder #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]), .out_valid(out_valid_v[2]),
      .out_ready(out_ready_v[2]), .sum(sum2), .cout(cout_v[2]), .overflow(ovf_v[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: plain integer add, signed overflow from operand/result signs.
   function automatic void ref_calc(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input logic ci, output logic [15:0] s, output logic c,
                                    output logic o);
      logic [31:0] mask;
      logic [31:0] t;
      mask = (32'd1 << w) - 32'd1;
      t    = ({16'h0, a} & mask) + ({16'h0, b} & mask) + {31'h0, ci};
      s    = 16'(t & mask);
      c    = t[w];
      o    = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
   endfunction

   // Compare process: on every falling edge check handshake and, when valid, the result.
   initial begin
      bit ev;
      bit er;
      for (int i = 0; i < NI; i++) have_op[i] = 1'b0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
               have_op[i] = 1'b0;
               chk($sformatf("dut%0d rst out_valid", i), {31'h0, out_valid_v[i]}, 32'd0);
               chk($sformatf("dut%0d rst in_ready", i), {31'h0, in_ready_v[i]}, 32'd1);
               chk($sformatf("dut%0d rst sum", i), {16'h0, sum_v[i]}, 32'd0);
               chk($sformatf("dut%0d rst cout", i), {31'h0, cout_v[i]}, 32'd0);
               chk($sformatf("dut%0d rst overflow", i), {31'h0, ovf_v[i]}, 32'd0);
            end else begin
               ev = have_op[i] && (n >= acc_edge[i] + N_T[i]);
               er = !have_op[i] || (ev && out_ready_v[i]);
               chk($sformatf("dut%0d out_valid", i), {31'h0, out_valid_v[i]}, {31'h0, ev});
               chk($sformatf("dut%0d in_ready", i), {31'h0, in_ready_v[i]}, {31'h0, er});
               if (ev) begin
                  chk($sformatf("dut%0d sum", i), {16'h0, sum_v[i]}, {16'h0, es[i]});
                  chk($sformatf("dut%0d cout", i), {31'h0, cout_v[i]}, {31'h0, ec[i]});
                  chk($sformatf("dut%0d overflow", i), {31'h0, ovf_v[i]}, {31'h0, eo[i]});
               end
               if (ev && out_ready_v[i]) have_op[i] = 1'b0;
               if (in_valid_v[i] && er) begin
                  have_op[i]  = 1'b1;
                  acc_edge[i] = n + 1;
                  ref_calc(W_T[i], a_v[i], b_v[i], cin_v[i], es[i], ec[i], eo[i]);
               end
            end
         end
      end
   end

   // Present operands and hold in_valid until accepted; returns at accept edge + 1.
   task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic ci);
      int k;
      a_v[i] = a;
      b_v[i] = b;
      cin_v[i] = ci;
      in_valid_v[i] = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready_v[i] && k < 100);
      chk($sformatf("dut%0d accept timeout", i), {31'h0, in_ready_v[i]}, 32'd1);
      @(posedge clk);
      #1;
      acc_n = n;
      in_valid_v[i] = 1'b0;
   endtask

   // Wait for out_valid, check literal result and latency; returns at next edge + 1.
   task automatic wait_result(input int i, input logic [15:0] s, input logic c, input logic o,
                              input int lat, input string name);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!out_valid_v[i] && k < 100);
      chk({name, " out_valid"}, {31'h0, out_valid_v[i]}, 32'd1);
      chk({name, " latency"}, n - acc_n, lat);
      chk({name, " sum"}, {16'h0, sum_v[i]}, {16'h0, s});
      chk({name, " cout"}, {31'h0, cout_v[i]}, {31'h0, c});
      chk({name, " overflow"}, {31'h0, ovf_v[i]}, {31'h0, o});
      $display("%s: sum=%0h cout=%0b overflow=%0b latency=%0d", name, sum_v[i], cout_v[i],
               ovf_v[i], n - acc_n);
      @(posedge clk);
      #1;
   endtask

   // Directed scenarios, then randomized traffic on the 16/4 instance.
   initial begin
      int k;
      for (int i = 0; i < NI; i++) begin
         in_valid_v[i] = 1'b0;
         out_ready_v[i] = 1'b1;
         cin_v[i] = 1'b0;
         a_v[i] = '0;
         b_v[i] = '0;
      end
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", {31'h0, out_valid_v[0]}, 32'd0);
      chk("reset in_ready", {31'h0, in_ready_v[0]}, 32'd1);
      chk("reset sum", {16'h0, sum_v[0]}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic adds on the bit-serial instance
      do_op(0, 16'h00, 16'h00, 1'b1);
      wait_result(0, 16'h01, 1'b0, 1'b0, 8, "t1 00+00+1");
      do_op(0, 16'hFF, 16'h01, 1'b0);
      wait_result(0, 16'h00, 1'b1, 1'b0, 8, "t2 FF+01");
      do_op(0, 16'h7F, 16'h01, 1'b0);
      wait_result(0, 16'h80, 1'b0, 1'b1, 8, "t2 7F+01");

      // backpressure: result held while new operands wait
      out_ready_v[0] = 1'b0;
      do_op(0, 16'h35, 16'h4A, 1'b0);
      wait_result(0, 16'h7F, 1'b0, 1'b0, 8, "t3 35+4A");
      a_v[0] = 16'h80;
      b_v[0] = 16'h80;
      cin_v[0] = 1'b0;
      in_valid_v[0] = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk("t3 hold out_valid", {31'h0, out_valid_v[0]}, 32'd1);
         chk("t3 hold in_ready", {31'h0, in_ready_v[0]}, 32'd0);
         chk("t3 hold sum", {16'h0, sum_v[0]}, 32'h7F);
      end
      @(posedge clk);
      #1;
      out_ready_v[0] = 1'b1;
      @(negedge clk);
      chk("t3 handoff in_ready", {31'h0, in_ready_v[0]}, 32'd1);
      @(posedge clk);
      #1;
      acc_n = n;
      in_valid_v[0] = 1'b0;
      wait_result(0, 16'h00, 1'b1, 1'b1, 8, "t3 80+80");

      // reset in the middle of an operation
      do_op(0, 16'h11, 16'h22, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t4 async out_valid", {31'h0, out_valid_v[0]}, 32'd0);
      chk("t4 async sum", {16'h0, sum_v[0]}, 32'd0);
      chk("t4 async cout", {31'h0, cout_v[0]}, 32'd0);
      chk("t4 async overflow", {31'h0, ovf_v[0]}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("t4 release in_ready", {31'h0, in_ready_v[0]}, 32'd1);
      @(posedge clk);
      #1;
      do_op(0, 16'h12, 16'h34, 1'b1);
      wait_result(0, 16'h47, 1'b0, 1'b0, 8, "t4 12+34+1");

      // whole word in one cycle
      do_op(2, 16'hAA, 16'h55, 1'b1);
      wait_result(2, 16'h00, 1'b1, 1'b0, 1, "t6 AA+55+1");
      do_op(2, 16'hFF, 16'hFF, 1'b1);
      wait_result(2, 16'hFF, 1'b1, 1'b0, 1, "t6 FF+FF+1");

      // randomized traffic with random backpressure on the 16/4 instance
      fork
         begin
            for (int j = 0; j < 1000; j++) begin
               if ($urandom_range(0, 7) == 0) begin
                  in_valid_v[1] = 1'b0;
                  @(posedge clk);
                  #1;
               end
               a_v[1] = 16'($urandom);
               b_v[1] = 16'($urandom);
               cin_v[1] = 1'($urandom);
               in_valid_v[1] = 1'b1;
               k = 0;
               do begin
                  @(negedge clk);
                  k++;
               end while (!in_ready_v[1] && k < 100);
               if (!in_ready_v[1]) chk("t5 accept timeout", {31'h0, in_ready_v[1]}, 32'd1);
               @(posedge clk);
               #1;
               if ((j % 100) == 99)
                  $display("t5: %0d random operations issued, a=%0h b=%0h", j + 1, a_v[1], b_v[1]);
            end
            in_valid_v[1] = 1'b0;
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready_v[1] = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready_v[1] = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
